lcd_hex_display: RTL and testbench

Downstream consumer of the MiniAlu LED result byte. It drives the Spartan-3E 16x2 character LCD (HD44780, 4-bit bus, write-only). After reset it runs the LCD power-up and configuration sequence. It then shows every byte handed to it as two upper-case ASCII hex characters at line 1, columns 0–1, so program results are visible without decoding the 8 LEDs.

---
 rtl/lcd_hex_display_pkg.sv | 49 ++++
 rtl/lcd_hex_display_if.sv | 21 ++
 rtl/lcd_nibble_writer.sv | 106 ++++++++++
 rtl/lcd_hex_display.sv | 175 +++++++++++++++++
 tb/tb_lcd_hex_display.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_hex_display_pkg.sv
// Shared types, HD44780 command bytes and helpers for the LCD hex display.
// The top FSM encoding and the nibble writer's phase encoding live here.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT  = 4'd0,
        INIT_N1   = 4'd1,
        INIT_N2   = 4'd2,
        INIT_N3   = 4'd3,
        INIT_N4   = 4'd4,
        CFG_FUNC  = 4'd5,
        CFG_ENTRY = 4'd6,
        CFG_DISP  = 4'd7,
        CFG_CLEAR = 4'd8,
        IDLE      = 4'd9,
        WR_ADDR   = 4'd10,
        WR_HI     = 4'd11,
        WR_LO     = 4'd12
    } lcd_state_e;

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_SETUP = 3'd1,
        W_HIGH  = 3'd2,
        W_HOLD  = 3'd3,
        W_POST  = 3'd4
    } wr_phase_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ADDR_L1  = 8'h80;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_hex_display_if.sv
// Host-side value strobe and LCD pin bundle for lcd_hex_display.
interface lcd_hex_display_if;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic       oInitDone;
    logic [3:0] oLCD_Data;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;

    modport master (
        output iData, iValid,
        input  oReady, oInitDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW
    );

    modport slave (
        input  iData, iValid,
        output oReady, oInitDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Sends one nibble (setup, E pulse, hold) and then waits post_wait cycles.
// wait_only skips the pin activity, so the power-up delay shares the one timer.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int P_T_E = 12,
    parameter int TW    = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wait_only,
    input  logic [3:0]    nibble,
    input  logic          rs,
    input  logic [TW-1:0] post_wait,
    output logic [3:0]    lcd_data,
    output logic          lcd_e,
    output logic          lcd_rs,
    output logic          done
);

    localparam logic [TW-1:0] T_E = TW'(P_T_E);

    wr_phase_e     phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] post_q, post_d;
    logic [3:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic          done_q, done_d;
    logic          last_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= W_IDLE;
            timer_q <= '0;
            post_q  <= '0;
            data_q  <= 4'h0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            post_q  <= post_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    // A phase loaded with N lasts max(N,1) cycles: it ends once the timer reaches 1.
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        post_d  = post_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_d  = 1'b0;
        last_s  = (timer_q <= TW'(1));
        case (phase_q)
            W_IDLE: begin
                if (start && wait_only) begin
                    phase_d = W_POST;
                    timer_d = post_wait;
                end else if (start) begin
                    phase_d = W_SETUP;
                    timer_d = T_E;
                    post_d  = post_wait;
                    data_d  = nibble;
                    rs_d    = rs;
                end else begin
                    phase_d = W_IDLE;
                end
            end
            W_SETUP, W_HIGH, W_HOLD: begin
                if (last_s) begin
                    phase_d = (phase_q == W_SETUP) ? W_HIGH :
                              (phase_q == W_HIGH)  ? W_HOLD : W_POST;
                    timer_d = (phase_q == W_HOLD) ? post_q : T_E;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            W_POST: begin
                if (last_s) begin
                    phase_d = W_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                phase_d = W_IDLE;
            end
        endcase
        e_d = (phase_d == W_HIGH);
    end

    assign lcd_data = data_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign done     = done_q;

endmodule

// File: rtl/lcd_hex_display.sv
// HD44780 4-bit driver: power-up init, configuration, then shows each strobed
// byte as two upper-case hex characters at line 1, columns 0-1.
module lcd_hex_display
    import lcd_pkg::*;
#(
    parameter int P_T_POWERUP = 750000,
    parameter int P_T_E       = 12,
    parameter int P_T_NIBBLE  = 50,
    parameter int P_T_CMD     = 2000,
    parameter int P_T_INIT1   = 205000,
    parameter int P_T_INIT2   = 5000,
    parameter int P_T_CLEAR   = 82000
) (
    input logic               Clock,
    input logic               Reset,
    lcd_hex_display_if.slave  bus
);

    localparam int P_MAX = imax(imax(imax(P_T_POWERUP, P_T_E), imax(P_T_NIBBLE, P_T_CMD)),
                                imax(imax(P_T_INIT1, P_T_INIT2), P_T_CLEAR));
    localparam int TW    = $clog2(P_MAX + 1);

    lcd_state_e    state_q, state_d;
    logic          lo_q, lo_d;
    logic          sent_q, sent_d;
    logic          pend_q, pend_d;
    logic [7:0]    pval_q, pval_d;
    logic [7:0]    disp_q, disp_d;
    logic          init_q, init_d;
    logic          ready_q, ready_d;

    logic          wr_start, wr_wait_only, wr_rs, wr_done, single_s;
    logic [3:0]    wr_nibble, init_nib_s;
    logic [7:0]    byte_s;
    logic [TW-1:0] wr_post;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= PWR_WAIT;
            lo_q    <= 1'b0;
            sent_q  <= 1'b0;
            pend_q  <= 1'b0;
            pval_q  <= 8'h00;
            disp_q  <= 8'h00;
            init_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            sent_q  <= sent_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            disp_q  <= disp_d;
            init_q  <= init_d;
            ready_q <= ready_d;
        end
    end

    // Sequencing: each non-idle state hands one nibble (or two for bytes) to the writer.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        sent_d  = sent_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        disp_d  = disp_q;
        init_d  = init_q;
        if (state_q == IDLE) begin
            if (pend_q) begin
                state_d = WR_ADDR;
                disp_d  = pval_q;
                pend_d  = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end else if (!sent_q) begin
            sent_d = 1'b1;
        end else if (wr_done && !single_s && !lo_q) begin
            sent_d = 1'b0;
            lo_d   = 1'b1;
        end else if (wr_done) begin
            sent_d = 1'b0;
            lo_d   = 1'b0;
            case (state_q)
                PWR_WAIT:  state_d = INIT_N1;
                INIT_N1:   state_d = INIT_N2;
                INIT_N2:   state_d = INIT_N3;
                INIT_N3:   state_d = INIT_N4;
                INIT_N4:   state_d = CFG_FUNC;
                CFG_FUNC:  state_d = CFG_ENTRY;
                CFG_ENTRY: state_d = CFG_DISP;
                CFG_DISP:  state_d = CFG_CLEAR;
                CFG_CLEAR: begin
                    state_d = IDLE;
                    init_d  = 1'b1;
                end
                WR_ADDR:   state_d = WR_HI;
                WR_HI:     state_d = WR_LO;
                WR_LO: begin
                    if (pend_q) begin
                        state_d = WR_ADDR;
                        disp_d  = pval_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default:   state_d = PWR_WAIT;
            endcase
        end else begin
            sent_d = sent_q;
        end
        // A strobe coinciding with the pending-to-display copy re-arms pending.
        if (bus.iValid) begin
            pend_d = 1'b1;
            pval_d = bus.iData;
        end else begin
            pend_d = pend_d;
        end
        ready_d = (state_d == IDLE) && !pend_d;
    end

    always_comb begin
        byte_s     = 8'h00;
        wr_rs      = 1'b0;
        single_s   = 1'b0;
        init_nib_s = 4'h3;
        wr_post    = TW'(P_T_CMD);
        case (state_q)
            PWR_WAIT:  begin single_s = 1'b1; wr_post = TW'(P_T_POWERUP); end
            INIT_N1:   begin single_s = 1'b1; wr_post = TW'(P_T_INIT1); end
            INIT_N2:   begin single_s = 1'b1; wr_post = TW'(P_T_INIT2); end
            INIT_N3:   begin single_s = 1'b1; end
            INIT_N4:   begin single_s = 1'b1; init_nib_s = 4'h2; end
            CFG_FUNC:  byte_s = LCD_FUNC_SET;
            CFG_ENTRY: byte_s = LCD_ENTRY;
            CFG_DISP:  byte_s = LCD_DISP_ON;
            CFG_CLEAR: begin byte_s = LCD_CLEAR; wr_post = TW'(P_T_CLEAR); end
            WR_ADDR:   byte_s = LCD_ADDR_L1;
            WR_HI:     begin byte_s = nibble_to_ascii(disp_q[7:4]); wr_rs = 1'b1; end
            WR_LO:     begin byte_s = nibble_to_ascii(disp_q[3:0]); wr_rs = 1'b1; end
            default:   byte_s = 8'h00;
        endcase
        if (!single_s && !lo_q) begin
            wr_post = TW'(P_T_NIBBLE);
        end else begin
            wr_post = wr_post;
        end
        wr_nibble    = single_s ? init_nib_s : (lo_q ? byte_s[3:0] : byte_s[7:4]);
        wr_start     = (state_q != IDLE) && !sent_q;
        wr_wait_only = (state_q == PWR_WAIT);
    end

    lcd_nibble_writer #(
        .P_T_E (P_T_E),
        .TW    (TW)
    ) u_writer (
        .clk       (Clock),
        .rst       (Reset),
        .start     (wr_start),
        .wait_only (wr_wait_only),
        .nibble    (wr_nibble),
        .rs        (wr_rs),
        .post_wait (wr_post),
        .lcd_data  (bus.oLCD_Data),
        .lcd_e     (bus.oLCD_E),
        .lcd_rs    (bus.oLCD_RS),
        .done      (wr_done)
    );

    assign bus.oReady    = ready_q;
    assign bus.oInitDone = init_q;
    assign bus.oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Self-checking bench: captures every E pulse, compares the nibble stream with
// expected init/update sequences and checks LCD bus timing continuously.
module tb_lcd_hex_display;

    localparam int T_PU  = 20;
    localparam int T_E   = 2;
    localparam int T_NIB = 3;
    localparam int T_CMD = 5;
    localparam int T_I1  = 8;
    localparam int T_I2  = 6;
    localparam int T_CLR = 10;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    lcd_hex_display_if bus();

    lcd_hex_display #(
        .P_T_POWERUP (T_PU),
        .P_T_E       (T_E),
        .P_T_NIBBLE  (T_NIB),
        .P_T_CMD     (T_CMD),
        .P_T_INIT1   (T_I1),
        .P_T_INIT2   (T_I2),
        .P_T_CLEAR   (T_CLR)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;
    logic [4:0] nibq[$];

    typedef struct {
        logic [7:0] val;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;
    } vec_t;
    vec_t tbl[6];

    // Required gap after nibble k of the stream since reset (init nibbles, then byte halves).
    function automatic int post_of(input int k);
        if (k == 0) return T_I1;
        if (k == 1) return T_I2;
        if (k < 4)  return T_CMD;
        if (((k - 4) % 2) == 0) return T_NIB;
        return (((k - 4) / 2) == 3) ? T_CLR : T_CMD;
    endfunction

    function automatic logic [7:0] ref_hex(input logic [3:0] n);
        int v;
        v = n;
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_min(input string name, input int act, input int min);
        vectors++;
        if (act < min) begin
            miscompares++;
            $display("FAIL %s: measured %0d cycles, minimum %0d", name, act, min);
        end
    endtask

    // Bus monitor: capture {RS,Data} on each E rise and check protocol timing.
    initial begin
        int cyc, nib_idx, last_chg, last_rise, last_fall;
        bit have_fall, prev_e, cur_e;
        logic [4:0] prev_dr, cur_dr;
        cyc = 0; nib_idx = 0; last_chg = 0; last_rise = 0; last_fall = 0;
        have_fall = 1'b0; prev_e = 1'b0; prev_dr = 5'h00;
        forever begin
            @(negedge Clock);
            cyc++;
            cur_e  = bus.oLCD_E;
            cur_dr = {bus.oLCD_RS, bus.oLCD_Data};
            check("rw_low", {31'd0, bus.oLCD_RW}, 32'd0);
            if (Reset) begin
                nibq.delete();
                nib_idx   = 0;
                have_fall = 1'b0;
                last_chg  = cyc;
            end else begin
                if (cur_dr !== prev_dr) begin
                    check("stable_while_e", {31'd0, (cur_e | prev_e)}, 32'd0);
                    if (have_fall) check_min("hold", cyc - last_fall, T_E);
                    last_chg = cyc;
                end
                if (cur_e && !prev_e) begin
                    check_min("setup", cyc - last_chg, T_E);
                    if (have_fall) check_min("post_wait", cyc - last_fall, 2 * T_E + post_of(nib_idx - 1));
                    nibq.push_back(cur_dr);
                    nib_idx++;
                    last_rise = cyc;
                end
                if (!cur_e && prev_e) begin
                    check_min("e_width", cyc - last_rise, T_E);
                    last_fall = cyc;
                    have_fall = 1'b1;
                end
            end
            prev_e  = cur_e;
            prev_dr = cur_dr;
        end
    end

    task automatic get_nib(output logic [4:0] v);
        int n;
        n = 0;
        while (nibq.size() == 0 && n < 400) begin
            @(negedge Clock);
            n++;
        end
        if (nibq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL nib_timeout: no E pulse within %0d cycles, expected one", n);
            v = 5'h1F;
        end else begin
            v = nibq.pop_front();
        end
    endtask

    task automatic expect_nib(input string name, input logic rs, input logic [3:0] nib);
        logic [4:0] v;
        get_nib(v);
        check(name, {27'd0, v}, {27'd0, rs, nib});
    endtask

    task automatic expect_byte(input string name, input logic rs, input logic [7:0] b);
        expect_nib({name, "_hi"}, rs, b[7:4]);
        expect_nib({name, "_lo"}, rs, b[3:0]);
    endtask

    task automatic expect_init();
        int n;
        expect_nib("init_n1", 1'b0, 4'h3);
        expect_nib("init_n2", 1'b0, 4'h3);
        expect_nib("init_n3", 1'b0, 4'h3);
        expect_nib("init_n4", 1'b0, 4'h2);
        expect_byte("cfg_func", 1'b0, 8'h28);
        expect_byte("cfg_entry", 1'b0, 8'h06);
        expect_byte("cfg_disp", 1'b0, 8'h0C);
        check("init_done_pre", {31'd0, bus.oInitDone}, 32'd0);
        expect_byte("cfg_clear", 1'b0, 8'h01);
        n = 0;
        while (!bus.oInitDone && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("init_done", {31'd0, bus.oInitDone}, 32'd1);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.oReady && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check(name, {31'd0, bus.oReady}, 32'd1);
    endtask

    task automatic strobe(input logic [7:0] v);
        bus.iData  = v;
        bus.iValid = 1'b1;
        @(negedge Clock);
        bus.iValid = 1'b0;
    endtask

    task automatic do_update(input string name, input logic [7:0] v,
                             input logic [7:0] hi, input logic [7:0] lo);
        strobe(v);
        check({name, "_ready_drop"}, {31'd0, bus.oReady}, 32'd0);
        expect_byte({name, "_addr"}, 1'b0, 8'h80);
        expect_byte({name, "_chr_hi"}, 1'b1, hi);
        expect_byte({name, "_chr_lo"}, 1'b1, lo);
        wait_ready({name, "_ready_back"});
        check({name, "_no_extra"}, nibq.size(), 32'd0);
    endtask

    initial begin
        int n;
        logic [4:0] v;
        logic [7:0] r;
        tbl[0] = '{8'hA5, 8'h41, 8'h35};
        tbl[1] = '{8'h00, 8'h30, 8'h30};
        tbl[2] = '{8'hFF, 8'h46, 8'h46};
        tbl[3] = '{8'h9A, 8'h39, 8'h41};
        tbl[4] = '{8'h3C, 8'h33, 8'h43};
        tbl[5] = '{8'h7E, 8'h37, 8'h45};
        bus.iData  = 8'h00;
        bus.iValid = 1'b0;

        // Reset state and power-up sequence.
        repeat (3) @(negedge Clock);
        check("rst_outputs", {24'd0, bus.oLCD_Data, bus.oLCD_E, bus.oLCD_RS, bus.oLCD_RW},
              32'd0);
        check("rst_flags", {30'd0, bus.oReady, bus.oInitDone}, 32'd0);
        Reset = 1'b0;
        n = 0;
        while (!bus.oLCD_E && n < 60) begin
            @(negedge Clock);
            n++;
        end
        check("first_e_window", {31'd0, (n >= T_PU + T_E && n <= T_PU + T_E + 6)}, 32'd1);
        check("first_e_data", {27'd0, bus.oLCD_RS, bus.oLCD_Data}, 32'h03);
        expect_init();
        wait_ready("ready_after_init");

        for (int i = 0; i < 6; i++) begin
            do_update("tbl", tbl[i].val, tbl[i].exp_hi, tbl[i].exp_lo);
        end

        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom_range(0, 255));
            do_update("rand", r, ref_hex(r[7:4]), ref_hex(r[3:0]));
        end

        // Overwrite while busy: only the latest pending value is shown.
        strobe(8'hA5);
        expect_byte("ow_addr", 1'b0, 8'h80);
        expect_nib("ow_hi_a", 1'b1, 4'h4);
        strobe(8'h3C);
        expect_nib("ow_hi_b", 1'b1, 4'h1);
        expect_nib("ow_lo_a", 1'b1, 4'h3);
        strobe(8'hF0);
        expect_nib("ow_lo_b", 1'b1, 4'h5);
        expect_byte("ow2_addr", 1'b0, 8'h80);
        expect_byte("ow2_hi", 1'b1, 8'h46);
        expect_byte("ow2_lo", 1'b1, 8'h30);
        wait_ready("ow_ready");
        check("ow_single_update", nibq.size(), 32'd0);

        // Strobe before init completes.
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);
        strobe(8'h09);
        expect_init();
        expect_byte("early_addr", 1'b0, 8'h80);
        expect_byte("early_hi", 1'b1, 8'h30);
        expect_byte("early_lo", 1'b1, 8'h39);
        wait_ready("early_ready");

        // Reset while E is high in WR_LO.
        strobe(8'h5A);
        expect_byte("abort_addr", 1'b0, 8'h80);
        expect_byte("abort_hi", 1'b1, 8'h35);
        get_nib(v);
        check("abort_lo_nib", {27'd0, v}, 32'h14);
        check("abort_e_high", {31'd0, bus.oLCD_E}, 32'd1);
        Reset = 1'b1;
        #1;
        check("abort_e_async", {31'd0, bus.oLCD_E}, 32'd0);
        repeat (3) @(negedge Clock);
        check("abort_init_clr", {31'd0, bus.oInitDone}, 32'd0);
        Reset = 1'b0;
        expect_init();
        wait_ready("abort_ready");
        repeat (30) @(negedge Clock);
        check("abort_pend_clr", nibq.size(), 32'd0);
        check("abort_ready_hold", {31'd0, bus.oReady}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
